ysyx_220066_dmem_resp: RTL and testbench

//   Data-memory responder for the ysyx_220066 core's load/store port. Sits on the

---
 rtl/ysyx_220066_dmem_resp.sv | 137 +++++++++++++
 tb/tb_ysyx_220066_dmem_resp.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_220066_dmem_resp.sv
// Fixed-latency doubleword data-memory responder for the ysyx_220066 load/store port.
// Optional build macro DMEM_MISALIGN_CHK_EN turns misaligned reads/writes into error responses.
module ysyx_220066_dmem_resp #(
   parameter int unsigned LAT        = 2,
   parameter logic [63:0] BASE       = 64'h8000_0000,
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter logic [63:0] ERR_DATA   = 64'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic        block,
   input  logic [63:0] addr,
   input  logic [7:0]  wmask,
   input  logic [63:0] data_wr,
   output logic [63:0] data_rd,
   output logic        valid,
   output logic        error,
   output logic        busy
);

   localparam int unsigned IDX_W = DEPTH_LOG2;
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);
   // One past the last in-window byte, kept 65 bits wide so the compare cannot wrap.
   localparam logic [64:0] LIMIT    = {1'b0, BASE} + (65'd8 << DEPTH_LOG2);

   logic [63:0] memArray [0:DEPTH-1];

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic             wr_q, wr_d;
   logic [7:0]       wmask_q, wmask_d;
   logic [63:0]      wdata_q, wdata_d;

   logic             accept;
   logic             inWindow;
   logic             misErr;
   logic [IDX_W-1:0] reqIdx;
   logic [63:0]      curWord;
   logic [63:0]      mergedWord;

   assign accept   = (state_q == S_IDLE) && (MemRd || MemWr) && !block;
   assign inWindow = (addr >= BASE) && ({1'b0, addr} < LIMIT);
   assign reqIdx   = IDX_W'((addr - BASE) >> 3);

`ifdef DMEM_MISALIGN_CHK_EN
   logic [15:0] shiftedMask;
   assign shiftedMask = {8'b0, wmask} << addr[2:0];
   assign misErr      = (MemRd && (addr[2:0] != 3'd0)) || (MemWr && (shiftedMask[15:8] != 8'd0));
`else
   assign misErr = 1'b0;
`endif

   // Post-write view of the addressed word; also what a combined read/write returns.
   assign curWord = memArray[idx_q];
   always_comb begin
      mergedWord = curWord;
      for (int i = 0; i < 8; i++) begin
         if (wr_q && wmask_q[i]) begin
            mergedWord[8*i +: 8] = wdata_q[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      err_d   = err_q;
      wr_d    = wr_q;
      wmask_d = wmask_q;
      wdata_d = wdata_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               idx_d   = reqIdx;
               err_d   = !inWindow || misErr;
               wr_d    = MemWr;
               wmask_d = wmask;
               wdata_d = data_wr;
               cnt_d   = CNT_INIT;
               state_d = (LAT <= 1) ? S_RESP : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         wr_q    <= 1'b0;
         wmask_q <= 8'd0;
         wdata_q <= 64'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         wr_q    <= wr_d;
         wmask_q <= wmask_d;
         wdata_q <= wdata_d;
      end
   end

   // The write lands on the edge leaving RESP, so a reset during RESP still cancels it.
   always_ff @(posedge clk) begin
      if (!rst && (state_q == S_RESP) && wr_q && !err_q) begin
         memArray[idx_q] <= mergedWord;
      end
   end

   assign valid   = (state_q == S_RESP);
   assign busy    = (state_q != S_IDLE);
   assign error   = valid && err_q;
   assign data_rd = !valid ? 64'd0 : (err_q ? ERR_DATA : mergedWord);

endmodule

// File: tb/tb_ysyx_220066_dmem_resp.sv
// Randomized scoreboard bench for ysyx_220066_dmem_resp against a byte-lane memory model.
// A driver pushes expected responses; an independent monitor pops them on every valid pulse.
module tb_ysyx_220066_dmem_resp;

   localparam int unsigned LAT      = 2;
   localparam logic [63:0] BASE     = 64'h8000_0000;
   localparam logic [63:0] WINDOW   = 64'h8000;
   localparam logic [63:0] ERR_DATA = 64'h0;

   logic        clk = 1'b0;
   logic        rst;
   logic        MemRd, MemWr, block;
   logic [63:0] addr;
   logic [7:0]  wmask;
   logic [63:0] data_wr;
   logic [63:0] data_rd;
   logic        valid, error, busy;

   typedef struct packed {
      logic        err;
      logic [63:0] data;
   } exp_t;

   exp_t        expQ [$];
   logic [63:0] model [longint unsigned];
   logic [63:0] pool [8];
   int          testsRun = 0;
   int          failCount = 0;

   ysyx_220066_dmem_resp #(
      .LAT(LAT), .BASE(BASE), .DEPTH_LOG2(12), .ERR_DATA(ERR_DATA)
   ) dut (
      .clk(clk), .rst(rst), .MemRd(MemRd), .MemWr(MemWr), .block(block),
      .addr(addr), .wmask(wmask), .data_wr(data_wr),
      .data_rd(data_rd), .valid(valid), .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Reference behaviour: a word per doubleword index, merged lane by lane.
   function automatic exp_t modelAccess(input logic rd, input logic wr, input logic [63:0] a,
                                        input logic [7:0] m, input logic [63:0] d);
      exp_t              r;
      logic              bad;
      longint unsigned   idx;
      logic [63:0]       word;
      bad = !(a >= BASE && (a - BASE) < WINDOW);
`ifdef DMEM_MISALIGN_CHK_EN
      if (rd && a[2:0] != 3'd0) bad = 1'b1;
      if (wr) for (int i = 0; i < 8; i++) if (m[i] && (i + int'(a[2:0])) >= 8) bad = 1'b1;
`else
      if (rd) bad = bad;
`endif
      r.err  = bad;
      r.data = ERR_DATA;
      if (!bad) begin
         idx  = longint'((a - BASE) / 8);
         word = model.exists(idx) ? model[idx] : 64'h0;
         if (wr) begin
            for (int i = 0; i < 8; i++) if (m[i]) word[8*i +: 8] = d[8*i +: 8];
            model[idx] = word;
         end
         r.data = word;
      end
      return r;
   endfunction

   // Issue one request at a negedge with the DUT idle; returns at the next idle negedge.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [63:0] a,
                                input logic [7:0] m, input logic [63:0] d,
                                input int preBlock, input logic blockAfter);
      int cycles;
      expQ.push_back(modelAccess(rd, wr, a, m, d));
      MemRd = rd; MemWr = wr; addr = a; wmask = m; data_wr = d;
      block = (preBlock > 0);
      for (int i = 0; i < preBlock; i++) begin
         @(negedge clk);
         checkOutput("blocked_busy", 64'(busy), 64'd0);
      end
      block = 1'b0;
      @(posedge clk);
      cycles = 0;
      forever begin
         @(negedge clk);
         cycles++;
         if (valid === 1'b1 || cycles > 20) break;
         addr    = {$urandom, $urandom};
         wmask   = 8'($urandom);
         data_wr = {$urandom, $urandom};
         block   = blockAfter;
      end
      checkOutput("latency", 64'(cycles), 64'(LAT));
      MemRd = 1'b0; MemWr = 1'b0; block = 1'b0;
      @(negedge clk);
      checkOutput("idle_busy", 64'(busy), 64'd0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (valid === 1'b1) begin
         if (expQ.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL unexpected_valid: got error=%b data=%h, expected no response", error, data_rd);
         end else begin
            e = expQ.pop_front();
            checkOutput("resp_error", 64'(error), 64'(e.err));
            checkOutput("resp_data", data_rd, e.data);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] a, d, junk;
      logic        rd, wr;
      rst = 1'b1; MemRd = 0; MemWr = 0; block = 0; addr = 0; wmask = 0; data_wr = 0;
      repeat (2) @(negedge clk);
      checkOutput("reset_valid", 64'(valid), 64'd0);
      checkOutput("reset_error", 64'(error), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_data", data_rd, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      pool = '{BASE, BASE + 64'h8, BASE + 64'h10, BASE + 64'h18,
               BASE + 64'h100, BASE + 64'h1000, BASE + 64'h4000, BASE + WINDOW - 64'h8};
      foreach (pool[i]) applyStimulus(1'b0, 1'b1, pool[i], 8'hFF, {$urandom, $urandom}, 0, 1'b0);

      applyStimulus(1'b0, 1'b1, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 64'h8000_0010, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 64'h8000_0010, 8'hF0, 64'h5555_6666_0000_0000, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 64'h8000_0010, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 64'h8000_0010, 8'h00, 64'h0, 0, 1'b0);

      applyStimulus(1'b1, 1'b0, 64'h7FFF_FFF8, 8'h00, 64'h0, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, BASE + WINDOW, 8'h00, 64'h0, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, BASE + WINDOW, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b0);
      applyStimulus(1'b0, 1'b1, 64'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, BASE, 8'h00, 64'h0, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, BASE + WINDOW - 64'h8, 8'h00, 64'h0, 0, 1'b0);

      applyStimulus(1'b1, 1'b0, pool[1], 8'h00, 64'h0, 3, 1'b0);
      applyStimulus(1'b1, 1'b0, pool[2], 8'h00, 64'h0, 0, 1'b1);

      // Write aborted by reset in its WAIT cycle: the model is deliberately not updated.
      MemWr = 1'b1; addr = pool[3]; wmask = 8'hFF; data_wr = 64'h0BAD_0BAD_0BAD_0BAD;
      @(posedge clk);
      @(negedge clk);
      checkOutput("wait_busy", 64'(busy), 64'd1);
      MemWr = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_valid", 64'(valid), 64'd0);
      @(negedge clk);
      applyStimulus(1'b1, 1'b0, pool[3], 8'h00, 64'h0, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, BASE + 64'h4, 8'h00, 64'h0, 0, 1'b0);

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 2))
            0:       begin rd = 1'b1; wr = 1'b0; end
            1:       begin rd = 1'b0; wr = 1'b1; end
            default: begin rd = 1'b1; wr = 1'b1; end
         endcase
         a = pool[$urandom_range(0, 7)] | 64'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : BASE + WINDOW + 64'(8 * $urandom_range(0, 15));
         d = {$urandom, $urandom};
         junk = 64'($urandom_range(0, 3) == 0 ? 0 : $urandom);
         applyStimulus(rd, wr, a, junk[7:0], d, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(negedge clk);
      checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
